cache_way_ram: RTL and testbench
================================

Name: cache_way_ram

Overview:
Multi-way, byte-writable cache data store with a built-in clear sequencer. It is the next generation of the single-way cache data RAM. It holds WAY_NUM ways of 2^ADDR_WIDTH lines and reads all ways in parallel for tag-compare selection. It adds read enable with a valid flag, write-first forwarding, an optional output pipeline register, and a hardware clear engine triggered by reset or flush. It sits under the cache controller, beside the tag/valid array.

Parameters:
DATA_WIDTH, 32, bits per line per way; multiple of 8
ADDR_WIDTH, 5, line index width; depth = 2^ADDR_WIDTH
WAY_NUM, 2, number of ways (1..8)
DATA_BYTE_NUM, DATA_WIDTH/8, byte lanes per line
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  single-cycle request to clear the whole array; honoured only in READY
init_busy  out  1  high while the clear sweep runs; all rd/wr requests are ignored
wr_en  in  1  write request
wr_way_en  in  WAY_NUM  way mask; any number of bits may be set
wr_addr  in  ADDR_WIDTH  write line index
wr_data  in  DATA_WIDTH  write data, common to all selected ways
wr_byte_en  in  DATA_BYTE_NUM  byte lane enables
rd_en  in  1  read request
rd_addr  in  ADDR_WIDTH  read line index
rd_data  out  WAY_NUM*DATA_WIDTH  all ways; way w occupies bits [w*DATA_WIDTH +: DATA_WIDTH]
rd_valid  out  1  rd_data carries the result of a read accepted LAT cycles earlier

Behaviour:
- States: INIT, READY.
- On rst: state enters INIT, clear counter is 0, init_busy=1, rd_valid=0, rd_data=0, and every pipeline stage is zeroed.
- INIT:
  - Each cycle, line[counter] is written with 0 in all ways and all bytes, then the counter increments.
  - After line 2^ADDR_WIDTH-1 is written, the state moves to READY on the next edge.
  - The sweep takes exactly 2^ADDR_WIDTH cycles. init_busy falls in the first READY cycle.
  - wr_en, rd_en and flush are ignored. rd_valid stays 0.
- READY with flush=1: the state moves to INIT with the counter at 0.
  - A write or read presented in the same cycle as flush is dropped.
  - Reads already in the pipeline still complete, with their rd_valid.
- Write (READY, wr_en=1):
  - For each way w with wr_way_en[w]=1 and each byte i with wr_byte_en[i]=1, byte i of line wr_addr is updated at the edge.
  - Unselected bytes and ways are unchanged.
  - wr_way_en=0 or wr_byte_en=0 is a legal no-op.
- Read (READY, rd_en=1):
  - The array is sampled at the edge.
  - OUT_REG=0: rd_data and rd_valid are updated at that edge (latency 1).
  - OUT_REG=1: one additional register stage is added (latency 2). rd_valid is delayed identically.
- rd_en=0: rd_data holds its previous value and rd_valid=0 for that slot. Back-to-back reads give one result per cycle.
- Simultaneous read and write to the same address in the same cycle is write-first:
  - For written ways, each enabled byte returns wr_data and each disabled byte returns the old content.
  - Unwritten ways return old content.
- Simultaneous read and write to different addresses are independent.
- Index ranges cover the full depth; there is no out-of-range case and no wrap beyond the clear counter.
- rst during INIT restarts the sweep from line 0.
- rst during READY discards in-flight reads; rd_valid=0 on the next cycle.

Test Plan:
- Reset, WAY_NUM=2, ADDR_WIDTH=5 -> init_busy=1 for exactly 32 cycles. Reads of all 32 lines then return 0 in both ways, with rd_valid 1 cycle after rd_en (OUT_REG=0) or 2 cycles (OUT_REG=1).
- Write addr 3, way mask 2'b10, data 0xAABBCCDD, byte_en 4'b0101; then read addr 3 -> way1=0x00BB00DD, way0=0x00000000.
- Same-cycle write addr 7, mask 2'b11, data 0x12345678, byte_en 4'b1111, with read addr 7 over old 0xFFFFFFFF -> both ways read 0x12345678 (forwarded). The next read also returns 0x12345678.
- Reads of addr 1,2,3 in consecutive cycles, preloaded 0x11,0x22,0x33 -> rd_valid high for 3 consecutive cycles with data 0x11,0x22,0x33. The cycle after the last read: rd_valid=0 and rd_data holds 0x33.
- Fill lines, pulse flush with a concurrent write to addr 0 -> write dropped, init_busy=1 for 32 cycles, all lines read 0 afterward.
- Assert rst at sweep cycle 10 -> init_busy remains 1 for a further full 32 cycles from the reset release. Assert rst with a read in flight (OUT_REG=1) -> no rd_valid pulse appears.

Source files
------------

// File: rtl/cache_way_ram.sv
`default_nettype none
// ============================================================================
// Module   : cache_way_ram
// Brief    : Multi-way byte-writable cache data store with a hardware clear
//            sequencer, write-first forwarding and optional output register.
// Revision : 1.0 - initial release
// ============================================================================
module cache_way_ram #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int WAY_NUM       = 2,
    parameter int DATA_BYTE_NUM = DATA_WIDTH / 8,
    parameter int OUT_REG       = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    output logic                            init_busy,
    input  logic                            wr_en,
    input  logic [WAY_NUM-1:0]              wr_way_en,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic [DATA_BYTE_NUM-1:0]        wr_byte_en,
    input  logic                            rd_en,
    input  logic [ADDR_WIDTH-1:0]           rd_addr,
    output logic [WAY_NUM*DATA_WIDTH-1:0]   rd_data,
    output logic                            rd_valid
);

    localparam int         c_DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [0:0] c_ST_INIT  = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;

    logic [0:0]                    r_state;
    logic [ADDR_WIDTH-1:0]         r_cnt;
    logic                          w_init_wr;
    logic                          w_wr_acc;
    logic                          w_rd_acc;
    logic [WAY_NUM*DATA_WIDTH-1:0] w_rd_word;
    logic [WAY_NUM*DATA_WIDTH-1:0] r_s1_data;
    logic                          r_s1_valid;

    // A flush cycle is still READY, so its own rd/wr requests must be masked here.
    assign w_init_wr = !rst && (r_state == c_ST_INIT);
    assign w_wr_acc  = (r_state == c_ST_READY) && !flush && wr_en;
    assign w_rd_acc  = (r_state == c_ST_READY) && !flush && rd_en;
    assign init_busy = (r_state == c_ST_INIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_INIT;
            r_cnt   <= '0;
        end else if (r_state == c_ST_INIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == {ADDR_WIDTH{1'b1}}) begin
                r_state <= c_ST_READY;
            end
        end else if (flush) begin
            r_state <= c_ST_INIT;
            r_cnt   <= '0;
        end
    end

    for (genvar w = 0; w < WAY_NUM; w++) begin : g_way
        logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
        logic [DATA_WIDTH-1:0] w_fwd;

        always_ff @(posedge clk) begin
            if (w_init_wr) begin
                r_mem[r_cnt] <= '0;
            end else if (!rst && w_wr_acc && wr_way_en[w]) begin
                for (int i = 0; i < DATA_BYTE_NUM; i++) begin
                    if (wr_byte_en[i]) begin
                        r_mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                    end
                end
            end
        end

        // Write-first: a same-address write this cycle overrides the enabled bytes.
        always_comb begin
            w_fwd = r_mem[rd_addr];
            if (w_wr_acc && wr_way_en[w] && (wr_addr == rd_addr)) begin
                for (int i = 0; i < DATA_BYTE_NUM; i++) begin
                    if (wr_byte_en[i]) begin
                        w_fwd[i*8 +: 8] = wr_data[i*8 +: 8];
                    end
                end
            end
        end

        assign w_rd_word[w*DATA_WIDTH +: DATA_WIDTH] = w_fwd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [WAY_NUM*DATA_WIDTH-1:0] r_s2_data;
        logic                          r_s2_valid;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s2_data  <= '0;
                r_s2_valid <= 1'b0;
            end else begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= r_s1_data;
                end
            end
        end

        assign rd_data  = r_s2_data;
        assign rd_valid = r_s2_valid;
    end else begin : g_no_out_reg
        assign rd_data  = r_s1_data;
        assign rd_valid = r_s1_valid;
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_way_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_way_ram
// Brief    : Directed bench for cache_way_ram, latency-1 and latency-2 builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_way_ram;

    localparam int c_DW = 32;
    localparam int c_AW = 5;
    localparam int c_WN = 2;

    typedef struct {
        logic        wr_en;
        logic [1:0]  way;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        rd_en;
        logic [4:0]  ra;
        logic        ev;
        logic [63:0] ed;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        wr_en;
    logic [1:0]  wr_way_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_byte_en;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic        busy0, busy1, rv0, rv1;
    logic [63:0] rd0, rd1;

    int          n_pass  = 0;
    int          n_total = 0;
    logic        prev_v;
    logic [63:0] prev_d;
    logic        saw_valid;
    vec_t        tbl [20];

    always #5 clk = ~clk;

    cache_way_ram #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .WAY_NUM(c_WN), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush), .init_busy(busy0),
        .wr_en(wr_en), .wr_way_en(wr_way_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd0), .rd_valid(rv0)
    );

    cache_way_ram #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .WAY_NUM(c_WN), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .init_busy(busy1),
        .wr_en(wr_en), .wr_way_en(wr_way_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd1), .rd_valid(rv1)
    );

    function automatic vec_t mk(input logic we, input logic [1:0] way, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [3:0] be, input logic re,
                                input logic [4:0] ra, input logic ev, input logic [63:0] ed);
        vec_t v;
        v.wr_en = we; v.way = way; v.wa = wa; v.wd = wd; v.be = be;
        v.rd_en = re; v.ra = ra; v.ev = ev; v.ed = ed;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic we, input logic [1:0] way, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [3:0] be, input logic re,
                         input logic [4:0] ra);
        wr_en = we; wr_way_en = way; wr_addr = wa; wr_data = wd; wr_byte_en = be;
        rd_en = re; rd_addr = ra;
    endtask

    // The latency-2 build must show, one cycle later, what the latency-1 build showed.
    task automatic step(input logic ev, input logic [63:0] ed, input string nm);
        tick();
        chk({nm, " lat1 valid"}, {63'd0, rv0}, {63'd0, ev});
        chk({nm, " lat1 data"},  rd0, ed);
        chk({nm, " lat2 valid"}, {63'd0, rv1}, {63'd0, prev_v});
        chk({nm, " lat2 data"},  rd1, prev_d);
        prev_v = ev;
        prev_d = ed;
    endtask

    task automatic count_busy(output int n0, output int n1);
        n0 = 0;
        n1 = 0;
        saw_valid = 1'b0;
        for (int k = 0; k < 100 && (busy0 || busy1); k++) begin
            if (busy0) n0++;
            if (busy1) n1++;
            if (rv0 || (rv1 && k > 0)) saw_valid = 1'b1;
            tick();
        end
    endtask

    task automatic read_all_zero(input string nm);
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 2'b00, 5'd0, 32'd0, 4'h0, 1'b1, 5'(a));
            step(1'b1, 64'd0, nm);
        end
        drive(1'b0, 2'b00, 5'd0, 32'd0, 4'h0, 1'b0, 5'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n0, n1;

        tbl[0]  = mk(1, 2'b10, 5'd3,  32'hAABBCCDD, 4'b0101, 0, 5'd0,  0, 64'h0);
        tbl[1]  = mk(0, 2'b00, 5'd0,  32'h0,        4'b0000, 1, 5'd3,  1, 64'h00BB00DD_00000000);
        tbl[2]  = mk(1, 2'b11, 5'd7,  32'hFFFFFFFF, 4'b1111, 0, 5'd0,  0, 64'h00BB00DD_00000000);
        tbl[3]  = mk(1, 2'b11, 5'd7,  32'h12345678, 4'b1111, 1, 5'd7,  1, 64'h12345678_12345678);
        tbl[4]  = mk(0, 2'b00, 5'd0,  32'h0,        4'b0000, 1, 5'd7,  1, 64'h12345678_12345678);
        tbl[5]  = mk(1, 2'b11, 5'd1,  32'h00000011, 4'b1111, 0, 5'd0,  0, 64'h12345678_12345678);
        tbl[6]  = mk(1, 2'b11, 5'd2,  32'h00000022, 4'b1111, 0, 5'd0,  0, 64'h12345678_12345678);
        tbl[7]  = mk(1, 2'b11, 5'd3,  32'h00000033, 4'b1111, 0, 5'd0,  0, 64'h12345678_12345678);
        tbl[8]  = mk(0, 2'b00, 5'd0,  32'h0,        4'b0000, 1, 5'd1,  1, 64'h00000011_00000011);
        tbl[9]  = mk(0, 2'b00, 5'd0,  32'h0,        4'b0000, 1, 5'd2,  1, 64'h00000022_00000022);
        tbl[10] = mk(0, 2'b00, 5'd0,  32'h0,        4'b0000, 1, 5'd3,  1, 64'h00000033_00000033);
        tbl[11] = mk(0, 2'b00, 5'd0,  32'h0,        4'b0000, 0, 5'd0,  0, 64'h00000033_00000033);
        tbl[12] = mk(1, 2'b01, 5'd3,  32'hAABBCCDD, 4'b1100, 1, 5'd3,  1, 64'h00000033_AABB0033);
        tbl[13] = mk(1, 2'b11, 5'd5,  32'hCAFEF00D, 4'b1111, 1, 5'd2,  1, 64'h00000022_00000022);
        tbl[14] = mk(0, 2'b00, 5'd0,  32'h0,        4'b0000, 1, 5'd5,  1, 64'hCAFEF00D_CAFEF00D);
        tbl[15] = mk(1, 2'b00, 5'd5,  32'h0,        4'b1111, 1, 5'd5,  1, 64'hCAFEF00D_CAFEF00D);
        tbl[16] = mk(1, 2'b11, 5'd5,  32'h0,        4'b0000, 1, 5'd5,  1, 64'hCAFEF00D_CAFEF00D);
        tbl[17] = mk(1, 2'b11, 5'd31, 32'hDEADBEEF, 4'b1111, 0, 5'd0,  0, 64'hCAFEF00D_CAFEF00D);
        tbl[18] = mk(0, 2'b00, 5'd0,  32'h0,        4'b0000, 1, 5'd31, 1, 64'hDEADBEEF_DEADBEEF);
        tbl[19] = mk(0, 2'b00, 5'd0,  32'h0,        4'b0000, 1, 5'd0,  1, 64'h0);

        rst = 1'b1;
        flush = 1'b0;
        drive(1'b0, 2'b00, 5'd0, 32'd0, 4'h0, 1'b0, 5'd0);
        tick();
        tick();
        chk("reset busy lat1",  {63'd0, busy0}, 64'd1);
        chk("reset busy lat2",  {63'd0, busy1}, 64'd1);
        chk("reset valid lat1", {63'd0, rv0}, 64'd0);
        chk("reset valid lat2", {63'd0, rv1}, 64'd0);
        chk("reset data lat1",  rd0, 64'd0);
        chk("reset data lat2",  rd1, 64'd0);
        rst = 1'b0;
        count_busy(n0, n1);
        chk("init cycles lat1", 64'(n0), 64'd32);
        chk("init cycles lat2", 64'(n1), 64'd32);
        chk("init no valid", {63'd0, saw_valid}, 64'd0);

        prev_v = 1'b0;
        prev_d = 64'd0;
        read_all_zero("post-reset zero");

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].wr_en, tbl[i].way, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].rd_en, tbl[i].ra);
            step(tbl[i].ev, tbl[i].ed, $sformatf("vec%0d", i));
        end

        // Flush with a concurrent write and read; the prior read must still drain.
        drive(1'b0, 2'b00, 5'd0, 32'd0, 4'h0, 1'b1, 5'd5);
        step(1'b1, 64'hCAFEF00D_CAFEF00D, "pre-flush read");
        flush = 1'b1;
        drive(1'b1, 2'b11, 5'd0, 32'h55555555, 4'hF, 1'b1, 5'd5);
        step(1'b0, 64'hCAFEF00D_CAFEF00D, "flush cycle");
        flush = 1'b0;
        chk("flush busy", {63'd0, busy0}, 64'd1);
        drive(1'b1, 2'b11, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 5'd5);
        count_busy(n0, n1);
        chk("flush cycles lat1", 64'(n0), 64'd32);
        chk("flush cycles lat2", 64'(n1), 64'd32);
        chk("flush no valid", {63'd0, saw_valid}, 64'd0);
        drive(1'b0, 2'b00, 5'd0, 32'd0, 4'h0, 1'b0, 5'd0);
        prev_v = 1'b0;
        prev_d = 64'hCAFEF00D_CAFEF00D;
        read_all_zero("post-flush zero");

        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("mid-sweep busy", {63'd0, busy0}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy(n0, n1);
        chk("restart cycles lat1", 64'(n0), 64'd32);
        chk("restart cycles lat2", 64'(n1), 64'd32);

        drive(1'b0, 2'b00, 5'd0, 32'd0, 4'h0, 1'b1, 5'd3);
        tick();
        chk("inflight lat1 valid", {63'd0, rv0}, 64'd1);
        rst = 1'b1;
        drive(1'b0, 2'b00, 5'd0, 32'd0, 4'h0, 1'b0, 5'd0);
        tick();
        chk("rst inflight lat2 valid", {63'd0, rv1}, 64'd0);
        chk("rst inflight lat2 data",  rd1, 64'd0);
        chk("rst inflight lat1 valid", {63'd0, rv0}, 64'd0);
        rst = 1'b0;
        tick();
        chk("rst after lat2 valid", {63'd0, rv1}, 64'd0);
        count_busy(n0, n1);
        chk("final ready", {63'd0, busy0 | busy1}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
